// File: rtl/fp8_pkg.sv
// Shared E4M3 types and constants for the float-adder issue/collect logic.
package fp8_pkg;

    typedef logic [7:0] e4m3_t;

    localparam e4m3_t E4M3_ZERO = 8'h00;
    localparam e4m3_t E4M3_ONE  = 8'h38;

    // One-hot sequencer states.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        WAIT = 3'b010,
        DONE = 3'b100
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers mask whatever it holds.
    always_ff @(posedge clock) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/float_add_sequencer_e4m3.sv
// Issues queued E4M3 operand pairs to a one-shot adder, one reset pulse per pair,
// and returns each sum (or a forced zero after timeout) on a valid/ready port.
module float_add_sequencer_e4m3
    import fp8_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8,
    parameter int SETTLE     = 2
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   in_valid,
    output logic   in_ready,
    input  e4m3_t  in_a,
    input  e4m3_t  in_b,
    output e4m3_t  add_a,
    output e4m3_t  add_b,
    output logic   add_reset,
    input  e4m3_t  add_y,
    input  logic   add_valid,
    output logic   out_valid,
    input  logic   out_ready,
    output e4m3_t  out_y,
    output logic   out_timeout,
    output logic   busy,
    output state_e state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends combinationally on ready, and data is stable while valid is held.

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] SETTLE_W = WW'(SETTLE);
    localparam logic [WW-1:0] LAST_W   = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] MAX_W    = '1;

    state_e        state_next;
    logic [WW-1:0] wcnt;
    logic [15:0]   head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          sum_ok;

    assign push   = in_valid && in_ready;
    assign pop    = (state == IDLE) && !fifo_empty;
    // The adder's valid flop may still show the previous op during the first cycles.
    assign sum_ok = add_valid && (wcnt >= SETTLE_W);

    sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty) state_next = WAIT;
            WAIT:    if (sum_ok || wcnt == LAST_W) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            add_reset   <= 1'b1;
            add_a       <= E4M3_ZERO;
            add_b       <= E4M3_ZERO;
            wcnt        <= '0;
            out_y       <= E4M3_ZERO;
            out_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            add_reset <= (state_next != WAIT);
            if (pop) begin
                add_a <= head[15:8];
                add_b <= head[7:0];
                wcnt  <= '0;
            end else if (state == WAIT && wcnt != MAX_W) begin
                wcnt <= wcnt + 1'b1;
            end
            if (state == WAIT && state_next == DONE) begin
                out_y       <= sum_ok ? add_y : E4M3_ZERO;
                out_timeout <= !sum_ok;
            end
        end
    end

    assign out_valid = (state == DONE);
    assign in_ready  = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty;

endmodule
